// File: rtl/dma_copy_wb.sv
// dma_copy_wb: word-copy DMA engine with a Wishbone register slave and a
// Wishbone master that copies LEN words SRC->DST in chunks of up to BURST.
// Ports: wb_clk_i/wb_rst_i clock and async reset; wbs_* register slave
// (SRC, DST, LEN, CTRL); wbm_* single-word bus master; irq_o done level.

module dma_copy_wb #(
  parameter int BURST = 4,
  parameter int LEN_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        irq_o
);

  localparam int CW = $clog2(BURST) + 1;
  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RGAP = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_WGAP = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]       state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic [CW-1:0]    chunk;
  logic [CW-1:0]    idx;
  logic             done;
  logic             irq_en;
  logic [31:0]      buf_q [BURST];

  logic             busy;
  logic             slv_req;
  logic             slv_wr;
  logic             start;
  logic             mst_ack;
  logic             last;
  logic [CW-1:0]    idx_nx;
  logic [LEN_W-1:0] len_nx;
  logic             unused_ok;

  assign busy      = state != S_IDLE;
  assign slv_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign slv_wr    = wbs_cyc_i & wbs_stb_i & wbs_ack_o & wbs_we_i;
  assign start     = slv_wr & (wbs_adr_i == 2'd3) & wbs_dat_i[0] & ~busy;
  assign mst_ack   = wbm_ack_i & wbm_stb_o;
  assign idx_nx    = idx + 1'b1;
  assign last      = idx_nx == chunk;
  assign len_nx    = len - 1'b1;
  assign irq_o     = done & irq_en;
  assign wbm_sel_o = 4'hf;
  assign unused_ok = ^wbs_sel_i;

  function automatic logic [CW-1:0] clip(input logic [LEN_W-1:0] n);
    if (n >= LEN_W'(BURST)) return CW'(BURST);
    return n[CW-1:0];
  endfunction

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= slv_req;
      if (slv_req) begin
        unique case (wbs_adr_i)
          2'd0: wbs_dat_o <= src;
          2'd1: wbs_dat_o <= dst;
          2'd2: wbs_dat_o <= 32'(len);
          2'd3: wbs_dat_o <= {29'b0, done, irq_en, busy};
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < BURST; i++) buf_q[i] <= '0;
    end else if (state == S_RD && mst_ack) begin
      buf_q[idx[IW-1:0]] <= wbm_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      chunk     <= '0;
      idx       <= '0;
      done      <= 1'b0;
      irq_en    <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      if (slv_wr && !busy) begin
        case (wbs_adr_i)
          2'd0: src <= {wbs_dat_i[31:2], 2'b00};
          2'd1: dst <= {wbs_dat_i[31:2], 2'b00};
          2'd2: len <= wbs_dat_i[LEN_W-1:0];
          default: ;
        endcase
      end
      if (slv_wr && wbs_adr_i == 2'd3) begin
        irq_en <= wbs_dat_i[1];
        if (wbs_dat_i[2]) done <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            done <= 1'b0;
            if (len == '0) begin
              state <= S_FIN;
            end else begin
              chunk     <= clip(len);
              idx       <= '0;
              state     <= S_RD;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b0;
              wbm_adr_o <= src;
            end
          end
        end
        S_RD: begin
          if (mst_ack) begin
            src       <= src + 32'd4;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            // the last read also idles one cycle, via WGAP, before writing
            if (last) begin
              idx   <= '0;
              state <= S_WGAP;
            end else begin
              idx   <= idx_nx;
              state <= S_RGAP;
            end
          end
        end
        S_RGAP: begin
          state     <= S_RD;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_we_o  <= 1'b0;
          wbm_adr_o <= src;
        end
        S_WGAP: begin
          state     <= S_WR;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_we_o  <= 1'b1;
          wbm_adr_o <= dst;
          wbm_dat_o <= buf_q[idx[IW-1:0]];
        end
        S_WR: begin
          if (mst_ack) begin
            dst       <= dst + 32'd4;
            len       <= len_nx;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            if (!last) begin
              idx   <= idx_nx;
              state <= S_WGAP;
            end else if (len_nx == '0) begin
              state <= S_FIN;
            end else begin
              chunk <= clip(len_nx);
              idx   <= '0;
              state <= S_RGAP;
            end
          end
        end
        S_FIN: begin
          // placed after the CLR_DONE write so a same-cycle set wins
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy_wb.sv
// tb_dma_copy_wb: randomized scoreboard bench for dma_copy_wb.
// Memory slave with variable ack latency; expected bus ops queued per copy.

module tb_dma_copy_wb;

  localparam int BURST = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [1:0]  wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'hf;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_ack_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;
  logic        irq_o;

  always #5 wb_clk_i = ~wb_clk_i;

  dma_copy_wb #(.BURST(BURST), .LEN_W(16)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i),
    .irq_o    (irq_o)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          acks = 0;
  int          cyc_seen = 0;
  int          lat_mode = 0;
  int          lat_fix = 1;
  int          lat_max = 4;
  int          lat_rr = 0;
  int          fin_chk = 0;
  logic        end_irq = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic int pick_lat();
    int l;
    if (lat_mode == 0) begin
      l = lat_fix;
    end else if (lat_mode == 1) begin
      l = (lat_rr % 3 == 0) ? 1 : (lat_rr % 3 == 1) ? 3 : 7;
      lat_rr++;
    end else begin
      l = $urandom_range(1, lat_max);
    end
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: chunked read-all then write-all, from plain address math
  task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                           input int n);
    txn_t t;
    int   c;
    for (int b = 0; b < n; b += BURST) begin
      c = (n - b < BURST) ? n - b : BURST;
      for (int i = 0; i < c; i++) begin
        t.adr = s + 32'((b + i) * 4);
        t.we  = 1'b0;
        t.dat = '0;
        exp_q.push_back(t);
      end
      for (int i = 0; i < c; i++) begin
        t.adr = d + 32'((b + i) * 4);
        t.we  = 1'b1;
        t.dat = init_val(s + 32'((b + i) * 4));
        exp_q.push_back(t);
      end
    end
  endtask

  initial begin : bus_slave
    logic act;
    int   cnt;
    int   gap;
    txn_t hold;
    txn_t e;
    act = 1'b0;
    cnt = 0;
    gap = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      wbm_ack_i = 1'b0;
      if (wb_rst_i) begin
        act = 1'b0;
        gap = 0;
        fin_chk = 0;
        continue;
      end
      if (wbm_cyc_o) cyc_seen++;
      if (fin_chk == 2) begin
        chk("irq_before_fin", 32'(irq_o), 32'd0);
        fin_chk = 1;
      end else if (fin_chk == 1) begin
        chk("irq_after_fin", 32'(irq_o), 32'(end_irq));
        fin_chk = 0;
      end
      if (gap == 1) begin
        chk("gap_idle", 32'(wbm_stb_o | wbm_cyc_o), 32'd0);
        gap = (exp_q.size() > 0) ? 2 : 0;
      end else if (gap == 2) begin
        chk("gap_resume", 32'(wbm_stb_o), 32'd1);
        gap = 0;
      end
      if (!act && wbm_stb_o) begin
        act = 1'b1;
        cnt = pick_lat();
        hold.adr = wbm_adr_o;
        hold.we  = wbm_we_o;
        hold.dat = wbm_dat_o;
      end else if (act) begin
        chk("hold_stb", 32'(wbm_stb_o), 32'd1);
        chk("hold_adr", wbm_adr_o, hold.adr);
        if (hold.we) chk("hold_dat", wbm_dat_o, hold.dat);
      end
      if (act) begin
        cnt--;
        if (cnt == 0) begin
          wbm_ack_i = 1'b1;
          act = 1'b0;
          gap = 1;
          acks++;
          if (hold.we) mem[hold.adr] = hold.dat;
          else wbm_dat_i = mem_rd(hold.adr);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got adr %h we %0d want none",
                     hold.adr, hold.we);
          end else begin
            e = exp_q.pop_front();
            chk("txn_adr", hold.adr, e.adr);
            chk("txn_we", 32'(hold.we), 32'(e.we));
            if (e.we) chk("txn_dat", hold.dat, e.dat);
            if (exp_q.size() == 0) fin_chk = 2;
          end
        end
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [1:0] a,
                         input logic [31:0] d, output logic [31:0] q);
    int n;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = a;
    wbs_dat_i = d;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!wbs_ack_o && n < 16);
    if (!wbs_ack_o) begin
      checks++;
      errors++;
      $display("FAIL wbs_ack_timeout: got no ack want ack");
    end
    q = wbs_dat_o;
    @(posedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, '0, q);
  endtask

  task automatic wait_idle();
    logic [31:0] q;
    int n;
    n = 0;
    do begin
      rd(2'd3, q);
      n++;
    end while (q[0] && n < 2000);
    if (q[0]) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy want idle");
    end
  endtask

  task automatic end_checks(input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic ie);
    logic [31:0] q;
    repeat (3) @(posedge wb_clk_i);
    rd(2'd2, q);
    chk("len_left", q, 32'd0);
    rd(2'd0, q);
    chk("src_end", q, s + 32'(n * 4));
    rd(2'd1, q);
    chk("dst_end", q, d + 32'(n * 4));
    rd(2'd3, q);
    chk("ctrl_done", q, {29'b0, 1'b1, ie, 1'b0});
    chk("irq_level", 32'(irq_o), 32'(ie));
    for (int i = 0; i < n; i++)
      chk("mem_copy", mem_rd(d + 32'(i * 4)), init_val(s + 32'(i * 4)));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    wr(2'd3, 32'h4);
    chk("irq_clr", 32'(irq_o), 32'd0);
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input int n, input logic ie);
    mem.delete();
    wr(2'd0, s);
    wr(2'd1, d);
    wr(2'd2, 32'(n));
    push_copy(s, d, n);
    end_irq = ie;
    wr(2'd3, {30'b0, ie, 1'b1});
    chk("start_stb", 32'(wbm_stb_o), 32'd1);
    wait_idle();
    end_checks(s, d, n, ie);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [31:0] s;
    logic [31:0] d;
    int          n;
    int          base;
    logic        ie;

    #1 wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_wdat", wbm_dat_o, 32'd0);
    chk("rst_sack", 32'(wbs_ack_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("sel_const", 32'(wbm_sel_o), 32'hf);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), q);
      chk("rst_reg", q, 32'd0);
    end

    lat_mode = 0;
    lat_fix  = 1;
    run_copy(32'h4000_0000, 32'h4000_1000, 6, 1'b1);

    mem.delete();
    wr(2'd2, 32'd0);
    base = cyc_seen;
    wr(2'd3, 32'h3);
    chk("zl_irq_early", 32'(irq_o), 32'd0);
    @(posedge wb_clk_i);
    #1;
    chk("zl_irq", 32'(irq_o), 32'd1);
    rd(2'd3, q);
    chk("zl_ctrl", q, 32'h6);
    chk("zl_no_cyc", 32'(cyc_seen), 32'(base));
    wr(2'd3, 32'h4);
    chk("zl_irq_clr", 32'(irq_o), 32'd0);

    lat_mode = 1;
    lat_rr   = 0;
    run_copy(32'h3000_0000, 32'h3000_8000, 3, 1'b0);

    lat_mode = 2;
    lat_max  = 3;
    s = 32'h5000_0000;
    d = 32'h5000_4000;
    mem.delete();
    wr(2'd0, s);
    wr(2'd1, d);
    wr(2'd2, 32'd8);
    push_copy(s, d, 8);
    end_irq = 1'b0;
    wr(2'd3, 32'h1);
    base = acks;
    n = 0;
    while (acks < base + 3 && n < 500) begin
      @(posedge wb_clk_i);
      n++;
    end
    chk("busy_wait", 32'(acks >= base + 3), 32'd1);
    wr(2'd0, 32'hDEAD_0000);
    wr(2'd3, 32'h1);
    rd(2'd0, q);
    chk("busy_src_live",
        32'(q != 32'hDEAD_0000 && q[1:0] == 2'b00 && q > s && q <= s + 32),
        32'd1);
    rd(2'd3, q);
    chk("busy_flag", 32'(q[0]), 32'd1);
    wait_idle();
    end_checks(s, d, 8, 1'b0);
    base = cyc_seen;
    repeat (20) @(posedge wb_clk_i);
    chk("no_restart", 32'(cyc_seen), 32'(base));

    for (int k = 0; k < 5; k++) begin
      s  = 32'h1000_0000 + (32'($urandom_range(0, 1023)) << 2);
      d  = 32'h2000_0000 + (32'($urandom_range(0, 1023)) << 2);
      n  = $urandom_range(1, 11);
      ie = 1'($urandom_range(0, 1));
      run_copy(s, d, n, ie);
    end

    lat_mode = 0;
    lat_fix  = 2;
    run_copy(32'hFFFF_FFF8, 32'h0000_1000, 3, 1'b1);

    lat_fix = 3;
    mem.delete();
    wr(2'd0, 32'h6000_0000);
    wr(2'd1, 32'h6000_1000);
    wr(2'd2, 32'd4);
    push_copy(32'h6000_0000, 32'h6000_1000, 4);
    end_irq = 1'b0;
    wr(2'd3, 32'h3);
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!(wbm_stb_o && wbm_we_o) && n < 200);
    chk("rst_wait_wr", 32'(wbm_stb_o && wbm_we_o), 32'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("rst_mid_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(wbm_stb_o), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int r = 0; r < 4; r++) begin
      rd(2'(r), q);
      chk("rst_mid_reg", q, 32'd0);
    end
    chk("rst_mid_irq", 32'(irq_o), 32'd0);
    chk("rst_mid_idle", 32'(wbm_cyc_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
